video_pixel_packer: RTL and testbench

- Parametrised successor to the fixed RGB565 byte aligner.
- Assembles 8-bit parallel-video bytes into whole pixels of run-time-selectable size (RAW8, RGB565, YUV422, RGB888) and emits them as an AXI-Stream pixel stream with frame and line markers.
- Outputs expanded 8-bit colour channels, supports output backpressure through a skid register, and flags malformed lines and overflow.
- Sits between the camera byte receiver and the video DMA/colour pipeline.

---
 rtl/video_pixel_packer_pkg.sv | 29 ++
 rtl/video_pixel_packer_skid.sv | 53 +++++
 rtl/video_pixel_packer.sv | 138 +++++++++++++
 tb/tb_video_pixel_packer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pixel_packer_pkg.sv
// Shared definitions for the pixel packer: format codes, bytes-per-pixel
// lookup and packer state encoding.
package video_pixel_packer_pkg;

  localparam logic [1:0] FMT_RAW8   = 2'd0;
  localparam logic [1:0] FMT_RGB565 = 2'd1;
  localparam logic [1:0] FMT_YUV422 = 2'd2;
  localparam logic [1:0] FMT_RGB888 = 2'd3;

  typedef enum logic {
    ST_WAIT_SOF = 1'b0,
    ST_ACTIVE   = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [1:0] fmt_bpp(input logic [1:0] f);
    case (f)
      FMT_RAW8:   fmt_bpp = 2'd1;
      FMT_RGB888: fmt_bpp = 2'd3;
      default:    fmt_bpp = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/video_pixel_packer_skid.sv
// Two-entry AXI-Stream output stage: registered output plus one skid entry.
// mark_i ORs MARK_BIT into the newest entry still waiting to be accepted.
module axis_skid_buf #(
  parameter int W        = 8,
  parameter int MARK_BIT = W-1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         mark_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic         ovf_o
);

  logic         o_v_q, s_v_q;
  logic [W-1:0] o_d_q, s_d_q;
  logic [W-1:0] mark_mask;

  assign mark_mask   = {{(W-1){1'b0}}, 1'b1} << MARK_BIT;
  assign out_valid_o = o_v_q;
  assign out_data_o  = o_d_q;
  // Both entries occupied and nothing leaving: the incoming pixel has nowhere to go.
  assign ovf_o       = in_valid_i && o_v_q && s_v_q && !out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_v_q <= 1'b0;
      s_v_q <= 1'b0;
      o_d_q <= '0;
      s_d_q <= '0;
    end else if (!o_v_q || out_ready_i) begin
      if (s_v_q) begin
        o_v_q <= 1'b1;
        o_d_q <= mark_i ? (s_d_q | mark_mask) : s_d_q;
        s_v_q <= in_valid_i;
        if (in_valid_i) s_d_q <= in_data_i;
      end else begin
        o_v_q <= in_valid_i;
        if (in_valid_i) o_d_q <= in_data_i;
      end
    end else if (!s_v_q) begin
      s_v_q <= in_valid_i;
      if (in_valid_i) s_d_q <= in_data_i;
      if (mark_i) o_d_q <= o_d_q | mark_mask;
    end else if (mark_i) begin
      s_d_q <= s_d_q | mark_mask;
    end
  end

endmodule

// File: rtl/video_pixel_packer.sv
// Assembles parallel-video bytes into whole pixels (RAW8/RGB565/YUV422/RGB888)
// and emits them as an AXI-Stream pixel stream with expanded 8-bit channels.
module video_pixel_packer
  import video_pixel_packer_pkg::*;
#(
  parameter int BYTE_W       = 8,
  parameter int BPP_MAX      = 3,
  parameter bit SWAP_DEFAULT = 1'b0
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic [BYTE_W-1:0]         tdata_in,
  input  logic                      tvalid_in,
  input  logic                      tlast_in,
  input  logic                      tuser_in,
  input  logic [1:0]                fmt,
  input  logic                      swap,
  output logic [BYTE_W*BPP_MAX-1:0] tdata_out,
  output logic                      tvalid_out,
  input  logic                      tready_out,
  output logic                      tlast_out,
  output logic                      tuser_out,
  output logic [7:0]                red_out,
  output logic [7:0]                green_out,
  output logic [7:0]                blue_out,
  output logic                      err_partial,
  output logic                      err_overflow,
  input  logic                      clr_err
);

  localparam int PW = BYTE_W*BPP_MAX;
  localparam int BW = PW + 24 + 2;

  state_e          state_q;
  logic [1:0]      idx_q, fmt_q;
  logic            swap_q, first_q, perr_q, ovf_q;
  logic [PW-1:0]   acc_q;

  logic            sof, take, done, push, partial, ovf_pulse;
  logic [1:0]      fmt_e, idx_e, bpp_e;
  logic            swap_e, first_e;
  logic [PW-1:0]   acc_e, acc_nx;
  logic [23:0]     d;
  rgb_t            rgb;
  logic [BW-1:0]   buf_in, buf_out;
  logic            buf_valid;

  // SOF restarts assembly immediately, so the SOF byte uses the fresh fmt/swap.
  assign sof     = tvalid_in && tuser_in;
  assign take    = tvalid_in && (sof || state_q == ST_ACTIVE);
  assign fmt_e   = sof ? fmt  : fmt_q;
  assign swap_e  = sof ? swap : swap_q;
  assign idx_e   = sof ? 2'd0 : idx_q;
  assign acc_e   = sof ? '0   : acc_q;
  assign first_e = sof | first_q;
  assign bpp_e   = fmt_bpp(fmt_e);
  assign done    = (idx_e == bpp_e - 2'd1);
  assign push    = take && done;
  assign partial = take && tlast_in && !done;

  always_comb begin
    if (!swap_e) acc_nx = {acc_e[PW-BYTE_W-1:0], tdata_in};
    else         acc_nx = acc_e | (PW'(tdata_in) << (BYTE_W*idx_e));
  end

  // Channel expansion: replicate MSBs into the missing LSBs.
  always_comb begin
    d   = 24'(acc_nx);
    rgb = '0;
    case (fmt_e)
      FMT_RAW8:   rgb = '{r: d[7:0], g: d[7:0], b: d[7:0]};
      FMT_RGB565: rgb = '{r: {d[15:11], d[15:13]},
                          g: {d[10:5],  d[10:9]},
                          b: {d[4:0],   d[4:2]}};
      FMT_YUV422: rgb = '{r: d[15:8], g: d[15:8], b: d[15:8]};
      default:    rgb = '{r: d[23:16], g: d[15:8], b: d[7:0]};
    endcase
  end

  assign buf_in = {tlast_in, first_e, rgb, acc_nx};

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_SOF;
      idx_q   <= 2'd0;
      fmt_q   <= FMT_RAW8;
      swap_q  <= SWAP_DEFAULT;
      first_q <= 1'b0;
      acc_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      perr_q <= partial;
      if (sof) begin
        state_q <= ST_ACTIVE;
        fmt_q   <= fmt;
        swap_q  <= swap;
      end
      if (take) begin
        if (done || tlast_in) begin
          idx_q <= 2'd0;
          acc_q <= '0;
        end else begin
          idx_q <= idx_e + 2'd1;
          acc_q <= acc_nx;
        end
        first_q <= done ? 1'b0 : first_e;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_pulse | (ovf_q & ~clr_err);
  end

  axis_skid_buf #(.W(BW), .MARK_BIT(BW-1)) u_skid (
    .clk         (pclk),
    .rst_n       (rst_n),
    .in_valid_i  (push),
    .in_data_i   (buf_in),
    .mark_i      (partial),
    .out_valid_o (buf_valid),
    .out_data_o  (buf_out),
    .out_ready_i (tready_out),
    .ovf_o       (ovf_pulse)
  );

  assign tvalid_out   = buf_valid;
  assign tdata_out    = buf_out[PW-1:0];
  assign blue_out     = buf_out[PW+7:PW];
  assign green_out    = buf_out[PW+15:PW+8];
  assign red_out      = buf_out[PW+23:PW+16];
  assign tuser_out    = buf_out[PW+24];
  assign tlast_out    = buf_out[PW+25];
  assign err_partial  = perr_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_video_pixel_packer.sv
// Directed bench for video_pixel_packer: a queue-based pixel model checked
// every cycle, plus literal expectations for each scenario.
module tb_video_pixel_packer;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [7:0]  tdata_in;
  logic        tvalid_in, tlast_in, tuser_in;
  logic [1:0]  fmt;
  logic        swap;
  logic [23:0] tdata_out;
  logic        tvalid_out, tready_out, tlast_out, tuser_out;
  logic [7:0]  red_out, green_out, blue_out;
  logic        err_partial, err_overflow, clr_err;

  always #5 pclk = ~pclk;

  video_pixel_packer dut (
    .pclk(pclk), .rst_n(rst_n), .tdata_in(tdata_in), .tvalid_in(tvalid_in),
    .tlast_in(tlast_in), .tuser_in(tuser_in), .fmt(fmt), .swap(swap),
    .tdata_out(tdata_out), .tvalid_out(tvalid_out), .tready_out(tready_out),
    .tlast_out(tlast_out), .tuser_out(tuser_out), .red_out(red_out),
    .green_out(green_out), .blue_out(blue_out), .err_partial(err_partial),
    .err_overflow(err_overflow), .clr_err(clr_err)
  );

  typedef struct {
    logic [23:0] d;
    logic        l, u;
    logic [7:0]  r, g, b;
  } pix_t;

  int   total = 0, bad = 0, perr_cnt = 0;
  pix_t q[$];
  pix_t obs[$];
  logic [7:0] bq[$];
  logic       m_active, m_swap, m_first, e_perr, e_ovf;
  logic [1:0] m_fmt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic pix_t mk_pix(input logic [23:0] d, input logic [1:0] f);
    pix_t p;
    p.d = d; p.l = 1'b0; p.u = 1'b0;
    case (f)
      2'd0: begin p.r = d[7:0]; p.g = d[7:0]; p.b = d[7:0]; end
      2'd1: begin p.r = {d[15:11], d[15:13]}; p.g = {d[10:5], d[10:9]}; p.b = {d[4:0], d[4:2]}; end
      2'd2: begin p.r = d[15:8]; p.g = d[15:8]; p.b = d[15:8]; end
      default: begin p.r = d[23:16]; p.g = d[15:8]; p.b = d[7:0]; end
    endcase
    return p;
  endfunction

  // Model: bytes collect into a list; the list becomes a pixel when it reaches
  // the format's size. q holds the pixels sitting in the two output slots.
  initial begin
    m_active = 0; m_swap = 0; m_first = 0; m_fmt = 0; e_perr = 0; e_ovf = 0;
    forever begin
      @(posedge pclk or negedge rst_n);
      if (!rst_n) begin
        q.delete(); bq.delete();
        m_active = 0; m_swap = 0; m_first = 0; m_fmt = 0; e_perr = 0; e_ovf = 0;
      end else begin
        logic part, drop;
        part = 0; drop = 0;
        if (q.size() > 0 && tready_out) void'(q.pop_front());
        if (tvalid_in) begin
          if (tuser_in) begin
            m_active = 1; m_fmt = fmt; m_swap = swap; m_first = 1; bq.delete();
          end
          if (m_active) begin
            int n;
            n = (m_fmt == 2'd0) ? 1 : (m_fmt == 2'd3) ? 3 : 2;
            bq.push_back(tdata_in);
            if (bq.size() == n) begin
              logic [23:0] d;
              pix_t p;
              d = 0;
              foreach (bq[i]) begin
                if (!m_swap) d = (d << 8) | 24'(bq[i]);
                else         d = d | (24'(bq[i]) << (8*i));
              end
              p = mk_pix(d, m_fmt);
              p.l = tlast_in; p.u = m_first;
              m_first = 0; bq.delete();
              if (q.size() < 2) q.push_back(p);
              else drop = 1;
            end else if (tlast_in) begin
              part = 1; bq.delete();
              if (q.size() > 0) q[q.size()-1].l = 1'b1;
            end
          end
        end
        e_perr = part;
        e_ovf  = drop | (e_ovf & ~clr_err);
      end
    end
  end

  initial begin
    forever begin
      @(negedge pclk);
      if (q.size() > 0) begin
        chk("tvalid", 32'(tvalid_out), 1);
        if (tvalid_out) begin
          chk("tdata", 32'(tdata_out), 32'(q[0].d));
          chk("tlast", 32'(tlast_out), 32'(q[0].l));
          chk("tuser", 32'(tuser_out), 32'(q[0].u));
          chk("red",   32'(red_out),   32'(q[0].r));
          chk("green", 32'(green_out), 32'(q[0].g));
          chk("blue",  32'(blue_out),  32'(q[0].b));
        end
      end else begin
        chk("tvalid_idle", 32'(tvalid_out), 0);
      end
      chk("err_partial",  32'(err_partial),  32'(e_perr));
      chk("err_overflow", 32'(err_overflow), 32'(e_ovf));
      if (err_partial) perr_cnt++;
      if (tvalid_out && tready_out) begin
        pix_t p;
        p.d = tdata_out; p.l = tlast_out; p.u = tuser_out;
        p.r = red_out; p.g = green_out; p.b = blue_out;
        obs.push_back(p);
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic l, input logic u);
    @(posedge pclk); #1;
    tdata_in = b; tvalid_in = 1; tlast_in = l; tuser_in = u;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      tvalid_in = 0; tlast_in = 0; tuser_in = 0;
    end
  endtask

  initial begin
    rst_n = 0; tdata_in = 0; tvalid_in = 0; tlast_in = 0; tuser_in = 0;
    fmt = 0; swap = 0; tready_out = 1; clr_err = 0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_tvalid", 32'(tvalid_out), 0);
    chk("rst_tdata",  32'(tdata_out), 0);
    chk("rst_red",    32'(red_out), 0);
    chk("rst_errs",   32'({err_partial, err_overflow, tlast_out, tuser_out}), 0);
    rst_n = 1;

    // Bytes and tlast before any SOF are ignored
    obs.delete();
    drive(8'h01, 0, 0); drive(8'h02, 1, 0); drive(8'h03, 0, 0); drive(8'h04, 1, 0);
    idle(4);
    chk("pre_sof_none", obs.size(), 0);

    // RGB565 swap=0
    obs.delete(); fmt = 2'd1; swap = 0;
    drive(8'hF8, 0, 1); drive(8'h00, 0, 0); drive(8'h07, 0, 0); drive(8'hE0, 1, 0);
    idle(4);
    chk("565_cnt", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("565_p0", obs[0].d, 24'hF800);
      chk("565_p0_ul", {obs[0].u, obs[0].l}, 2'b10);
      chk("565_p0_rg", {obs[0].r, obs[0].g}, 16'hFF00);
      chk("565_p1", obs[1].d, 24'h07E0);
      chk("565_p1_ul", {obs[1].u, obs[1].l}, 2'b01);
      chk("565_p1_rg", {obs[1].r, obs[1].g}, 16'h00FF);
    end

    // RGB888 line of 3 pixels
    obs.delete(); fmt = 2'd3;
    drive(8'h11, 0, 1); drive(8'h22, 0, 0); drive(8'h33, 0, 0);
    drive(8'h44, 0, 0); drive(8'h55, 0, 0); drive(8'h66, 0, 0);
    drive(8'h77, 0, 0); drive(8'h88, 0, 0); drive(8'h99, 1, 0);
    idle(4);
    chk("888_cnt", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("888_p0", obs[0].d, 24'h112233);
      chk("888_p2", obs[2].d, 24'h778899);
      chk("888_last", {obs[0].l, obs[1].l, obs[2].l}, 3'b001);
      chk("888_rgb", {obs[1].r, obs[1].g, obs[1].b}, 24'h445566);
    end

    // Partial line then a realigned line
    obs.delete(); perr_cnt = 0; fmt = 2'd1;
    drive(8'h12, 0, 1); drive(8'h34, 0, 0); drive(8'h56, 1, 0);
    drive(8'hAB, 0, 0); drive(8'hCD, 1, 0);
    idle(4);
    chk("part_perr", perr_cnt, 1);
    chk("part_cnt", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("part_p0", {obs[0].d, obs[0].l}, {24'h1234, 1'b0});
      chk("part_p1", {obs[1].d, obs[1].l}, {24'hABCD, 1'b1});
    end

    // Swap, YUV422 and RAW8 colour mapping
    obs.delete(); swap = 1;
    drive(8'h00, 0, 1); drive(8'hF8, 1, 0);
    swap = 0; fmt = 2'd2;
    drive(8'h80, 0, 1); drive(8'h40, 1, 0);
    fmt = 2'd0;
    drive(8'h5A, 1, 1);
    idle(4);
    chk("mix_cnt", obs.size(), 3);
    if (obs.size() == 3) begin
      chk("swap_p", {obs[0].d, obs[0].r}, {24'hF800, 8'hFF});
      chk("yuv_p", {obs[1].d, obs[1].r, obs[1].g, obs[1].b}, {24'h8040, 24'h808080});
      chk("raw_p", {obs[2].d, obs[2].b, obs[2].u, obs[2].l}, {24'h5A, 8'h5A, 2'b11});
    end

    // Partial line while stalled marks the held pixel as last
    obs.delete(); perr_cnt = 0; fmt = 2'd1; tready_out = 0;
    drive(8'h01, 0, 1); drive(8'h02, 0, 0); drive(8'h03, 1, 0);
    idle(2); tready_out = 1; idle(3);
    chk("stall_part_cnt", obs.size(), 1);
    if (obs.size() == 1) chk("stall_part_p", {obs[0].d, obs[0].u, obs[0].l}, {24'h0102, 2'b11});
    chk("stall_part_perr", perr_cnt, 1);

    // Backpressure overflow with RAW8
    obs.delete(); fmt = 2'd0; tready_out = 0;
    drive(8'h01, 0, 1); drive(8'h02, 0, 0); drive(8'h03, 0, 0); drive(8'h04, 0, 0);
    idle(2);
    chk("bp_ovf", 32'(err_overflow), 1);
    chk("bp_held", obs.size(), 0);
    tready_out = 1; idle(4);
    chk("bp_cnt", obs.size(), 2);
    if (obs.size() == 2) chk("bp_order", {obs[0].d, obs[0].u, obs[1].d}, {24'h01, 1'b1, 24'h02});
    chk("bp_ovf_sticky", 32'(err_overflow), 1);
    @(posedge pclk); #1 clr_err = 1;
    @(posedge pclk); #1 clr_err = 0;
    chk("bp_clr", 32'(err_overflow), 0);

    // Reset mid-pixel and mid-stall
    obs.delete(); fmt = 2'd1; tready_out = 0;
    drive(8'hAA, 0, 1); drive(8'hBB, 0, 0); drive(8'hCC, 0, 0);
    @(posedge pclk); #1 tvalid_in = 0;
    #2 rst_n = 0;
    #1;
    chk("mrst_tvalid", 32'(tvalid_out), 0);
    chk("mrst_tdata", 32'(tdata_out), 0);
    chk("mrst_misc", 32'({red_out, err_partial, err_overflow, tlast_out, tuser_out}), 0);
    @(posedge pclk); #1 rst_n = 1; tready_out = 1;
    drive(8'hDD, 0, 0); drive(8'hEE, 1, 0);
    idle(3);
    chk("mrst_wait_sof", obs.size(), 0);
    drive(8'h12, 0, 1); drive(8'h34, 1, 0);
    idle(4);
    chk("mrst_cnt", obs.size(), 1);
    if (obs.size() == 1) chk("mrst_p", {obs[0].d, obs[0].u, obs[0].l}, {24'h1234, 2'b11});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
